// File: rtl/mem_arbiter_pkg.sv
// Shared typedefs for the CPU/loader memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_OWN = 2'd1,
        LD_OWN  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// CPU/loader single-port memory arbiter with locked loader bursts.
// Optional CPU stall counter enabled by defining MEM_ARB_STALL_CNT_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW        = 5,
    parameter int DW        = 8,
    parameter int BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_halt,
    input  logic          ld_req,
    input  logic          ld_wr,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    input  logic          ld_lock,
    output logic          cpu_gnt,
    output logic          ld_gnt,
    output logic          cpu_rvalid,
    output logic          ld_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_STALL_CNT_EN
    ,
    output logic [15:0]   cpu_stall_cnt
`endif
);

    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);

    arb_state_t    state;
    arb_state_t    cur;
    logic [CW-1:0] burst_cnt;
    logic          ld_win;

    // Arbitration during reset behaves as if the state were already IDLE.
    assign cur = rst ? IDLE : state;

    always_comb begin
        ld_win = 1'b0;
        if (cpu_req && ld_req) begin
            if (cpu_halt)
                ld_win = 1'b1;
            else if (cur == LD_OWN)
                ld_win = ld_lock && (burst_cnt < BMAX);
            else if (cur == CPU_OWN)
                ld_win = 1'b1;
            else
                ld_win = 1'b0;
        end else begin
            ld_win = ld_req;
        end
    end

    assign cpu_gnt = cpu_req && !ld_win;
    assign ld_gnt  = ld_req && ld_win;
    assign rdata   = mem_rdata;

    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_rd    = !cpu_wr;
            mem_wr    = cpu_wr;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ld_gnt) begin
            mem_rd    = !ld_wr;
            mem_wr    = ld_wr;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            cpu_rvalid <= 1'b0;
            ld_rvalid  <= 1'b0;
        end else begin
            if (cpu_gnt)
                state <= CPU_OWN;
            else if (ld_gnt)
                state <= LD_OWN;
            else
                state <= IDLE;
            if (ld_gnt)
                burst_cnt <= (burst_cnt == BMAX) ? BMAX : burst_cnt + 1'b1;
            else
                burst_cnt <= '0;
            cpu_rvalid <= cpu_gnt && !cpu_wr;
            ld_rvalid  <= ld_gnt && !ld_wr;
        end
    end

`ifdef MEM_ARB_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            cpu_stall_cnt <= '0;
        else if (cpu_req && !cpu_gnt && cpu_stall_cnt != 16'hFFFF)
            cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants/read data,
// a negedge monitor pops and compares whenever the DUT grants or returns data.
module tb_mem_arbiter;

    typedef struct {
        logic       ld;
        logic       wr;
        logic [4:0] addr;
        logic [7:0] wdata;
    } gexp_t;

    typedef struct {
        logic       ld;
        logic [7:0] data;
    } rvexp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_wr, cpu_halt;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       ld_req, ld_wr, ld_lock;
    logic [4:0] ld_addr;
    logic [7:0] ld_wdata;
    logic       cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid;
    logic [7:0] rdata;
    logic       mem_rd, mem_wr;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
`ifdef MEM_ARB_STALL_CNT_EN
    logic [15:0] cpu_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    gexp_t  gq[$];
    rvexp_t rq[$];
    gexp_t  g;
    rvexp_t r;
    logic [7:0] mem [32];

    always #5 clk = ~clk;

    mem_arbiter #(.AW(5), .DW(8), .BURST_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_halt(cpu_halt),
        .ld_req(ld_req), .ld_wr(ld_wr), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_lock(ld_lock),
        .cpu_gnt(cpu_gnt), .ld_gnt(ld_gnt),
        .cpu_rvalid(cpu_rvalid), .ld_rvalid(ld_rvalid), .rdata(rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STALL_CNT_EN
        , .cpu_stall_cnt(cpu_stall_cnt)
`endif
    );

    // Memory contents start as addr ^ 8'h36, so 5'h0A reads back 8'h3C.
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(i) ^ 8'h36;
        mem_rdata = 8'h00;
    end

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        checks++;
        if (cpu_gnt && ld_gnt) begin
            errors++;
            $display("FAIL both_gnt cpu_gnt=%b ld_gnt=%b want one-hot", cpu_gnt, ld_gnt);
        end
        if (cpu_gnt || ld_gnt) begin
            if (gq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_gnt cpu=%b ld=%b addr=%h", cpu_gnt, ld_gnt, mem_addr);
            end else begin
                g = gq.pop_front();
                if ({ld_gnt, cpu_gnt, mem_rd, mem_wr, mem_addr, mem_wdata} !==
                    {g.ld, !g.ld, !g.wr, g.wr, g.addr, g.wdata}) begin
                    errors++;
                    $display("FAIL gnt got ld=%b cpu=%b rd=%b wr=%b a=%h d=%h want ld=%b wr=%b a=%h d=%h",
                             ld_gnt, cpu_gnt, mem_rd, mem_wr, mem_addr, mem_wdata,
                             g.ld, g.wr, g.addr, g.wdata);
                end
            end
        end else if ({mem_rd, mem_wr, mem_addr, mem_wdata} !== 15'd0) begin
            errors++;
            $display("FAIL idle_mem rd=%b wr=%b a=%h d=%h want all 0",
                     mem_rd, mem_wr, mem_addr, mem_wdata);
        end
        if (cpu_rvalid || ld_rvalid) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid cpu=%b ld=%b", cpu_rvalid, ld_rvalid);
            end else begin
                r = rq.pop_front();
                if ({ld_rvalid, cpu_rvalid, rdata} !== {r.ld, !r.ld, r.data}) begin
                    errors++;
                    $display("FAIL rvalid got ld=%b cpu=%b rdata=%h want ld=%b rdata=%h",
                             ld_rvalid, cpu_rvalid, rdata, r.ld, r.data);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic wr,
                           input logic [4:0] a, input logic [7:0] d);
        cpu_req = req; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_ld(input logic req, input logic wr, input logic [4:0] a,
                          input logic [7:0] d, input logic lock);
        ld_req = req; ld_wr = wr; ld_addr = a; ld_wdata = d; ld_lock = lock;
    endtask

    task automatic exp_g(input logic ld, input logic wr, input logic [4:0] a,
                         input logic [7:0] d, input logic [7:0] rd_data);
        gexp_t e;
        rvexp_t v;
        e.ld = ld; e.wr = wr; e.addr = a; e.wdata = d;
        gq.push_back(e);
        if (!wr) begin
            v.ld = ld; v.data = rd_data;
            rq.push_back(v);
        end
    endtask

    task automatic idle();
        set_cpu(0, 0, 5'h00, 8'h00);
        set_ld(0, 0, 5'h00, 8'h00, 0);
        cpu_halt = 0;
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    initial begin
        rst = 1;
        idle();
        tick();
        tick();
        check_bit("reset_cpu_rvalid", cpu_rvalid, 1'b0);
        check_bit("reset_ld_rvalid", ld_rvalid, 1'b0);
`ifdef MEM_ARB_STALL_CNT_EN
        check_bit("reset_stall_zero", cpu_stall_cnt == 16'd0, 1'b1);
`endif
        rst = 0;

        // solo CPU read
        set_cpu(1, 0, 5'h0A, 8'h00);
        exp_g(0, 0, 5'h0A, 8'h00, 8'h3C);
        tick();
        idle();
        tick();

        // contention from IDLE, then alternation
        set_cpu(1, 0, 5'h01, 8'h11);
        set_ld(1, 0, 5'h02, 8'h22, 0);
        exp_g(0, 0, 5'h01, 8'h11, 8'h37);
        exp_g(1, 0, 5'h02, 8'h22, 8'h34);
        exp_g(0, 0, 5'h01, 8'h11, 8'h37);
        exp_g(1, 0, 5'h02, 8'h22, 8'h34);
        repeat (4) tick();
        idle();

        // reach CPU_OWN, then locked burst: LD x4, CPU, LD
        set_cpu(1, 0, 5'h04, 8'h00);
        exp_g(0, 0, 5'h04, 8'h00, 8'h32);
        tick();
        set_ld(1, 0, 5'h06, 8'h00, 1);
        repeat (4) exp_g(1, 0, 5'h06, 8'h00, 8'h30);
        exp_g(0, 0, 5'h04, 8'h00, 8'h32);
        exp_g(1, 0, 5'h06, 8'h00, 8'h30);
        repeat (6) tick();
        idle();

        // loader write then CPU read of the same word
        set_ld(1, 1, 5'h03, 8'h77, 0);
        exp_g(1, 1, 5'h03, 8'h77, 8'h00);
        tick();
        idle();
        set_cpu(1, 0, 5'h03, 8'h00);
        exp_g(0, 0, 5'h03, 8'h00, 8'h77);
        tick();
        idle();

        // halt: loader wins for 10 cycles, then CPU once halt drops
        cpu_halt = 1;
        set_cpu(1, 0, 5'h01, 8'h00);
        set_ld(1, 1, 5'h09, 8'h5A, 0);
        repeat (10) exp_g(1, 1, 5'h09, 8'h5A, 8'h00);
        repeat (10) tick();
        cpu_halt = 0;
        exp_g(0, 0, 5'h01, 8'h00, 8'h37);
        tick();
        idle();
        tick();

        // loader read granted while reset is sampled: no rvalid, state IDLE
        rst = 1;
        set_ld(1, 0, 5'h02, 8'h00, 1);
        exp_g(1, 0, 5'h02, 8'h00, 8'h00);
        void'(rq.pop_back());
        tick();
        rst = 0;
        check_bit("reset_read_no_rvalid", ld_rvalid, 1'b0);
        set_cpu(1, 0, 5'h01, 8'h00);
        exp_g(0, 0, 5'h01, 8'h00, 8'h37);
        tick();
        idle();
        tick();

`ifdef MEM_ARB_STALL_CNT_EN
        rst = 1;
        tick();
        rst = 0;
        cpu_halt = 1;
        set_cpu(1, 0, 5'h01, 8'h00);
        set_ld(1, 1, 5'h09, 8'h5A, 0);
        repeat (3) exp_g(1, 1, 5'h09, 8'h5A, 8'h00);
        repeat (3) tick();
        cpu_halt = 0;
        exp_g(0, 0, 5'h01, 8'h00, 8'h37);
        tick();
        idle();
        check_bit("stall_cnt_3", cpu_stall_cnt == 16'd3, 1'b1);
        tick();
        cpu_halt = 1;
        set_cpu(1, 0, 5'h01, 8'h00);
        set_ld(1, 1, 5'h09, 8'h5A, 0);
        for (int i = 0; i < 65540; i++) begin
            exp_g(1, 1, 5'h09, 8'h5A, 8'h00);
            tick();
        end
        check_bit("stall_sat", cpu_stall_cnt == 16'hFFFF, 1'b1);
        exp_g(1, 1, 5'h09, 8'h5A, 8'h00);
        tick();
        check_bit("stall_sat_hold", cpu_stall_cnt == 16'hFFFF, 1'b1);
        idle();
`endif

        repeat (3) tick();
        check_bit("gnt_queue_drained", gq.size() == 0, 1'b1);
        check_bit("rvalid_queue_drained", rq.size() == 0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- AW, 5: address width.
- DW, 8: data width.
- BURST_MAX, 4: maximum consecutive locked loader grants while the CPU waits.

REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cpu_req  in  1  CPU memory access request.
- cpu_wr  in  1  CPU write (1) / read (0).
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_halt  in  1  CPU halted.
- ld_req  in  1  loader request.
- ld_wr  in  1  loader write / read.
- ld_addr  in  AW  loader address.
- ld_wdata  in  DW  loader write data.
- ld_lock  in  1  loader requests burst ownership.
- cpu_gnt  out  1  CPU access accepted this cycle.
- ld_gnt  out  1  loader access accepted this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- ld_rvalid  out  1  loader read data valid.
- rdata  out  DW  read data, shared by both requesters.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid one cycle after mem_rd.

Function
REQ-004 At most one of cpu_gnt and ld_gnt SHALL be 1 in any cycle.
REQ-005 The gnt outputs and all mem_* command outputs SHALL be combinational from the current requests and the arbitration state; the winner's addr, wdata and wr SHALL be muxed onto mem_*.
REQ-006 mem_rd SHALL equal gnt AND NOT wr of the winner; mem_wr SHALL equal gnt AND wr of the winner.
REQ-007 With no winner, mem_rd and mem_wr SHALL be 0 and mem_addr/mem_wdata SHALL be 0.
REQ-008 The arbitration state SHALL be IDLE, CPU_OWN or LD_OWN, set at each clock edge to the last cycle's grantee, or IDLE if nothing was granted.
REQ-009 If only one requester asserts req, that requester SHALL win.
REQ-010 If both requesters assert req, the winner SHALL be chosen by the first matching rule:
- cpu_halt=1: loader wins.
- LD_OWN, ld_lock=1 and burst_cnt<BURST_MAX: loader wins.
- LD_OWN otherwise: CPU wins.
- CPU_OWN: loader wins.
- IDLE: CPU wins.
REQ-011 burst_cnt SHALL be a $clog2(BURST_MAX+1)-bit counter with these updates:
- Increments (saturating at BURST_MAX) on each ld_gnt.
- Clears on any cpu_gnt or any cycle with no grant.
REQ-012 cpu_rvalid/ld_rvalid SHALL be registered versions of the respective read grants, so they assert exactly one cycle after the granted read.
REQ-013 rdata SHALL pass mem_rdata through unchanged.
REQ-014 Write grants SHALL never produce rvalid.
REQ-015 Back-to-back grants SHALL be allowed every cycle with no bubble; throughput SHALL be one access per cycle.
REQ-016 Changing a request while it is not granted SHALL have no side effects; requesters SHALL hold req and the command fields until gnt.

Reset
REQ-017 While rst=1 at a clock edge, the block SHALL take these reset values:
- State = IDLE.
- burst_cnt = 0.
- cpu_rvalid = ld_rvalid = 0.
- Stall counter (if present) = 0.
REQ-018 A read granted in the cycle rst is sampled SHALL NOT produce rvalid.
REQ-019 While rst=1, the gnt and mem_* outputs SHALL follow REQ-005 to REQ-010 from state IDLE, with no memory write suppression required.

Configuration
REQ-020 When MEM_ARB_STALL_CNT_EN is defined, the block SHALL provide output port cpu_stall_cnt[15:0] with this behaviour:
- Increments each cycle in which cpu_req=1 and cpu_gnt=0.
- Saturates at 16'hFFFF.
- Cleared by reset.
REQ-021 When MEM_ARB_STALL_CNT_EN is undefined, the port and counter logic SHALL be absent, with all other behaviour identical.

Structure
REQ-022 The state enum arb_state_t {IDLE, CPU_OWN, LD_OWN} SHALL be added to package typedefs.
REQ-023 The block SHALL be a single module with no sub-modules.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Solo CPU read: cpu_req=1, cpu_wr=0, addr 5'h0A, mem_rdata 8'h3C -> cpu_gnt=1 and mem_rd=1 in the same cycle; cpu_rvalid=1 and rdata=8'h3C the next cycle.
- Contention from IDLE, then alternation: both requesting, no lock -> grants CPU, LD, CPU, LD.
- Locked burst: state CPU_OWN, ld_lock=1, both requesting continuously -> LD granted 4 consecutive cycles, then CPU, then LD.
- Halt: cpu_halt=1, both requesting for 10 cycles -> ld_gnt=1 in all 10, cpu_gnt=0 in all 10.
- Reset mid-read: loader read granted, rst=1 at the next edge -> ld_rvalid stays 0; state IDLE afterwards.
- Stall counter (macro defined): CPU blocked 3 cycles, then granted -> cpu_stall_cnt=3; saturation held at 16'hFFFF.
